// File: rtl/clock_source_controller_if.sv
// Signal bundle between the clock quality monitor / supervisor and the clock source controller.
// The slave modport is the controller's view; master is the driving side.
interface clock_source_controller_if;
    logic       enable;
    logic       meas_done;
    logic       ref_clock_valid;
    logic       sys_clock_valid;
    logic       clocks_synchronized;
    logic [7:0] ref_fault_count;
    logic       sel_ref;
    logic       holdover;
    logic       alarm;
    logic       ref_lockout;
    logic [2:0] state;
    logic       switch_pulse;
    logic [7:0] switch_count;

    modport slave (
        input  enable, meas_done, ref_clock_valid, sys_clock_valid, clocks_synchronized,
        input  ref_fault_count,
        output sel_ref, holdover, alarm, ref_lockout, state, switch_pulse, switch_count
    );

    modport master (
        output enable, meas_done, ref_clock_valid, sys_clock_valid, clocks_synchronized,
        output ref_fault_count,
        input  sel_ref, holdover, alarm, ref_lockout, state, switch_pulse, switch_count
    );
endinterface

// File: rtl/clock_source_controller.sv
// Supervisory FSM choosing between the qualified 10 MHz reference and the 100 MHz system clock,
// with holdover, free-run, fault alarm and reference lockout. All outputs are registered.
module clock_source_controller #(
    parameter int unsigned QUAL_WINDOWS     = 4,
    parameter int unsigned FAULT_WINDOWS    = 2,
    parameter int unsigned HOLDOVER_WINDOWS = 16,
    parameter int unsigned FAULT_LIMIT      = 16
) (
    input  logic                        clk_sys,
    input  logic                        rst_n,
    clock_source_controller_if.slave    bus
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StQualify  = 3'd1;
    localparam logic [2:0] StLocked   = 3'd2;
    localparam logic [2:0] StHoldover = 3'd3;
    localparam logic [2:0] StFreerun  = 3'd4;
    localparam logic [2:0] StFault    = 3'd5;

    localparam logic [7:0] QualWin  = 8'(QUAL_WINDOWS);
    localparam logic [7:0] FaultWin = 8'(FAULT_WINDOWS);
    localparam logic [7:0] HoldWin  = 8'(HOLDOVER_WINDOWS);
    localparam logic [7:0] FaultLim = 8'(FAULT_LIMIT);

    logic [2:0] state_q, state_d;
    logic [7:0] qual_q, qual_d;
    logic [7:0] bad_q, bad_d;
    logic [7:0] hold_q, hold_d;
    logic       lockout_q, lockout_d;
    logic       sel_ref_q, sel_ref_d;
    logic       holdover_q, holdover_d;
    logic       alarm_q, alarm_d;
    logic       pulse_q, pulse_d;
    logic [7:0] swcnt_q, swcnt_d;

    logic       over_limit;
    logic       lock_eff;
    logic [7:0] qual_inc, bad_inc, hold_inc;

    always_comb begin
        over_limit = bus.ref_fault_count >= FaultLim;
        // Lockout as seen by this window's evaluation, including a same-window trip.
        lock_eff   = lockout_q | (bus.meas_done & over_limit & (state_q != StIdle));
        qual_inc   = qual_q + 8'd1;
        bad_inc    = bad_q + 8'd1;
        hold_inc   = hold_q + 8'd1;

        state_d   = state_q;
        qual_d    = qual_q;
        bad_d     = bad_q;
        hold_d    = hold_q;
        lockout_d = lockout_q;

        if (!bus.enable) begin
            state_d   = StIdle;
            qual_d    = 8'd0;
            bad_d     = 8'd0;
            hold_d    = 8'd0;
            lockout_d = 1'b0;
        end else begin
            if (bus.meas_done && (state_q != StIdle) && over_limit) begin
                lockout_d = 1'b1;
            end
            case (state_q)
                StIdle: state_d = StQualify;
                StQualify: begin
                    if (bus.meas_done) begin
                        if (!bus.sys_clock_valid) begin
                            state_d = StFault;
                        end else if (bus.ref_clock_valid && bus.clocks_synchronized && !lock_eff) begin
                            qual_d = qual_inc;
                            if (qual_inc >= QualWin) state_d = StLocked;
                        end else begin
                            qual_d = 8'd0;
                        end
                    end
                end
                StLocked: begin
                    if (bus.meas_done) begin
                        if (!bus.ref_clock_valid) begin
                            bad_d = bad_inc;
                            if (bad_inc >= FaultWin) state_d = StHoldover;
                        end else begin
                            bad_d = 8'd0;
                        end
                    end
                end
                StHoldover: begin
                    if (bus.meas_done) begin
                        hold_d = hold_inc;
                        if (!bus.sys_clock_valid) begin
                            state_d = StFault;
                        end else if (bus.ref_clock_valid && !lock_eff) begin
                            state_d = StQualify;
                        end else if (hold_inc >= HoldWin) begin
                            state_d = StFreerun;
                        end
                    end
                end
                StFreerun: begin
                    if (bus.meas_done) begin
                        if (!bus.sys_clock_valid) begin
                            state_d = StFault;
                        end else if (bus.ref_clock_valid && !lock_eff) begin
                            state_d = StQualify;
                        end
                    end
                end
                StFault: begin
                    if (bus.meas_done && bus.sys_clock_valid) state_d = StFreerun;
                end
                default: state_d = StIdle;
            endcase
        end

        if (state_d != state_q) begin
            qual_d = 8'd0;
            bad_d  = 8'd0;
            hold_d = 8'd0;
        end

        sel_ref_d  = (state_d == StLocked);
        holdover_d = (state_d == StHoldover);
        alarm_d    = (state_d == StFault);
        pulse_d    = (sel_ref_d != sel_ref_q);
        swcnt_d    = (pulse_d && (swcnt_q != 8'hFF)) ? swcnt_q + 8'd1 : swcnt_q;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            qual_q     <= 8'd0;
            bad_q      <= 8'd0;
            hold_q     <= 8'd0;
            lockout_q  <= 1'b0;
            sel_ref_q  <= 1'b0;
            holdover_q <= 1'b0;
            alarm_q    <= 1'b0;
            pulse_q    <= 1'b0;
            swcnt_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            qual_q     <= qual_d;
            bad_q      <= bad_d;
            hold_q     <= hold_d;
            lockout_q  <= lockout_d;
            sel_ref_q  <= sel_ref_d;
            holdover_q <= holdover_d;
            alarm_q    <= alarm_d;
            pulse_q    <= pulse_d;
            swcnt_q    <= swcnt_d;
        end
    end

    assign bus.state        = state_q;
    assign bus.sel_ref      = sel_ref_q;
    assign bus.holdover     = holdover_q;
    assign bus.alarm        = alarm_q;
    assign bus.ref_lockout  = lockout_q;
    assign bus.switch_pulse = pulse_q;
    assign bus.switch_count = swcnt_q;

endmodule
